// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage
// Brief    : PC/fetch front stage with direct-mapped 2-bit BHT + BTB predictor.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned BHT_BITS = 6,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        iClk,
   input  logic        iRst,
   output logic [31:0] oImemAddr,
   output logic        oImemReq,
   input  logic [31:0] iImemData,
   input  logic        iImemReady,
   input  logic        iStall,
   input  logic        iHalt,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   input  logic        iUpdateEn,
   input  logic [31:0] iUpdatePC,
   input  logic        iUpdateTaken,
   input  logic [31:0] iUpdateTarget,
   output logic [31:0] oInstruction,
   output logic [31:0] oNextPC,
   output logic        oBranchPredict,
   output logic        oValid
);
   localparam int unsigned ENTRIES = 1 << BHT_BITS;
   localparam int unsigned TAG_W   = 32 - BHT_BITS;

   typedef enum logic [0:0] {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc_q, next_pc_d;
   logic        pred_q, pred_d;
   logic        valid_q, valid_d;

   logic [1:0]       cnt_q        [ENTRIES];
   logic             btb_valid_q  [ENTRIES];
   logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
   logic [31:0]      btb_target_q [ENTRIES];

   logic [BHT_BITS-1:0] lookup_idx;
   logic [BHT_BITS-1:0] update_idx;
   logic                predict_taken;
   logic [31:0]         predicted_pc;
   logic [1:0]          cnt_upd;
   logic                req;
   logic                accept;

   assign lookup_idx    = pc_q[BHT_BITS-1:0];
   assign update_idx    = iUpdatePC[BHT_BITS-1:0];
   assign predict_taken = cnt_q[lookup_idx][1] && btb_valid_q[lookup_idx] &&
                          (btb_tag_q[lookup_idx] == pc_q[31:BHT_BITS]);
   assign predicted_pc  = predict_taken ? btb_target_q[lookup_idx] : pc_q + 32'd1;

   // A halting cycle already issues no request so the output takes a bubble.
   assign req    = (state_q == FETCH) && !iStall && !iHalt;
   assign accept = req && iImemReady && !iRedirect;

   assign oImemAddr      = pc_q;
   assign oImemReq       = req;
   assign oInstruction   = instr_q;
   assign oNextPC        = next_pc_q;
   assign oBranchPredict = pred_q;
   assign oValid         = valid_q;

   always_comb begin
      cnt_upd = cnt_q[update_idx];
      if (iUpdateTaken) begin
         if (cnt_q[update_idx] != 2'b11) cnt_upd = cnt_q[update_idx] + 2'd1;
      end else begin
         if (cnt_q[update_idx] != 2'b00) cnt_upd = cnt_q[update_idx] - 2'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      next_pc_d = next_pc_q;
      pred_d    = pred_q;
      valid_d   = valid_q;
      if (iRedirect) begin
         state_d   = FETCH;
         pc_d      = iRedirectPC;
         instr_d   = NOP;
         next_pc_d = 32'd0;
         pred_d    = 1'b0;
         valid_d   = 1'b0;
      end else if (accept) begin
         pc_d      = predicted_pc;
         instr_d   = iImemData;
         next_pc_d = pc_q + 32'd1;
         pred_d    = predict_taken;
         valid_d   = 1'b1;
      end else begin
         if (!iStall) begin
            instr_d = NOP;
            pred_d  = 1'b0;
            valid_d = 1'b0;
         end
         if (iHalt) state_d = HALTED;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= NOP;
         next_pc_q <= 32'd0;
         pred_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         next_pc_q <= next_pc_d;
         pred_q    <= pred_d;
         valid_q   <= valid_d;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i]       <= 2'b01;
            btb_valid_q[i] <= 1'b0;
         end
      end else if (iUpdateEn) begin
         cnt_q[update_idx] <= cnt_upd;
         if (iUpdateTaken) btb_valid_q[update_idx] <= 1'b1;
      end
   end

   // Tag/target are qualified by btb_valid_q, so they need no reset.
   always_ff @(posedge iClk) begin
      if (iUpdateEn && iUpdateTaken) begin
         btb_tag_q[update_idx]    <= iUpdatePC[31:BHT_BITS];
         btb_target_q[update_idx] <= iUpdateTarget;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_stage
// Brief    : Directed + random bench for instruction_fetch_stage with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data;
   logic        imem_ready, stall, halt, redirect, upd_en, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] instr, next_pc;
   logic        bpred, valid;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_npc;
   logic        m_pred, m_valid, m_halted;
   int          m_cnt [64];
   bit          m_bv  [64];
   logic [31:0] m_tag [64];
   logic [31:0] m_tgt [64];

   always #5 clk = ~clk;
   assign imem_data = imem_addr + 32'h100;

   instruction_fetch_stage #(.RESET_PC(RESET_PC), .BHT_BITS(6), .NOP(NOP)) dut (
      .iClk(clk), .iRst(rst),
      .oImemAddr(imem_addr), .oImemReq(imem_req),
      .iImemData(imem_data), .iImemReady(imem_ready),
      .iStall(stall), .iHalt(halt),
      .iRedirect(redirect), .iRedirectPC(redirect_pc),
      .iUpdateEn(upd_en), .iUpdatePC(upd_pc),
      .iUpdateTaken(upd_taken), .iUpdateTarget(upd_target),
      .oInstruction(instr), .oNextPC(next_pc),
      .oBranchPredict(bpred), .oValid(valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_halted = 0;
      m_instr = NOP; m_npc = 0; m_pred = 0; m_valid = 0;
      for (int i = 0; i < 64; i++) begin
         m_cnt[i] = 1; m_bv[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
      end
   endtask

   function automatic bit m_taken();
      int idx;
      idx = int'(m_pc % 64);
      return (m_cnt[idx] >= 2) && m_bv[idx] && (m_tag[idx] == (m_pc >> 6));
   endfunction

   task automatic model_step(input bit s, input bit rdy, input bit h, input bit rd,
                             input logic [31:0] rpc, input bit ue, input logic [31:0] upc,
                             input bit ut, input logic [31:0] utg);
      bit          tk;
      logic [31:0] nxt;
      int          idx;
      tk  = m_taken();
      nxt = tk ? m_tgt[int'(m_pc % 64)] : m_pc + 1;
      if (rd) begin
         m_pc = rpc; m_halted = 0;
         m_instr = NOP; m_npc = 0; m_pred = 0; m_valid = 0;
      end else if (!m_halted && !s && !h && rdy) begin
         m_instr = m_pc + 32'h100; m_npc = m_pc + 1; m_pred = tk; m_valid = 1;
         m_pc = nxt;
      end else begin
         if (!s) begin m_instr = NOP; m_valid = 0; end
         if (h) m_halted = 1;
      end
      if (ue) begin
         idx = int'(upc % 64);
         if (ut) begin
            m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            m_bv[idx] = 1; m_tag[idx] = upc >> 6; m_tgt[idx] = utg;
         end else begin
            m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
         end
      end
   endtask

   // One clock: drive inputs, check request side, clock it, check registered outputs.
   task automatic cycle(input bit s, input bit rdy, input bit h, input bit rd,
                        input logic [31:0] rpc, input bit ue, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utg);
      stall = s; imem_ready = rdy; halt = h; redirect = rd; redirect_pc = rpc;
      upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utg;
      #1;
      chk("imem_req", {31'd0, imem_req}, {31'd0, !m_halted && !s && !h});
      chk("imem_addr", imem_addr, m_pc);
      model_step(s, rdy, h, rd, rpc, ue, upc, ut, utg);
      @(posedge clk); #1;
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("instr", instr, m_instr);
      if (m_valid) begin
         chk("next_pc", next_pc, m_npc);
         chk("bpred", {31'd0, bpred}, {31'd0, m_pred});
      end
   endtask

   task automatic fetch(input bit rdy);
      cycle(0, rdy, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic redir(input logic [31:0] pc);
      cycle(0, 1, 0, 1, pc, 0, 0, 0, 0);
   endtask

   task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
      cycle(1, 1, 0, 0, 0, 1, pc, tk, tg);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_instr"}, instr, NOP);
      chk({tag, "_next_pc"}, next_pc, 32'd0);
      chk({tag, "_bpred"}, {31'd0, bpred}, 32'd0);
      chk({tag, "_addr"}, imem_addr, RESET_PC);
   endtask

   initial begin
      rst = 1; stall = 0; imem_ready = 1; halt = 0; redirect = 0; redirect_pc = 0;
      upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 0;
      model_reset();

      // Zero-wait streaming
      fetch(1);
      chk("first_instr", instr, 32'h100);
      chk("first_next_pc", next_pc, 32'd1);
      fetch(1);
      fetch(1);
      chk("third_instr", instr, 32'h102);
      fetch(1);
      fetch(1);
      // Two wait states on address 5
      fetch(0);
      fetch(0);
      chk("wait_addr", imem_addr, 32'd5);
      fetch(1);
      chk("after_wait_instr", instr, 32'h105);
      chk("after_wait_next_pc", next_pc, 32'd6);

      // Stall hold and release
      repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("stall_hold_instr", instr, 32'h105);
      fetch(1);
      chk("stall_release_instr", instr, 32'h106);

      // Branch predictor training on PC 0x10
      upd(32'h10, 1, 32'h40);
      upd(32'h10, 1, 32'h40);
      redir(32'h10);
      fetch(1);
      chk("bp_taken", {31'd0, bpred}, 32'd1);
      chk("bp_target_addr", imem_addr, 32'h40);
      upd(32'h10, 0, 0);
      redir(32'h10);
      fetch(1);
      chk("bp_still_taken", {31'd0, bpred}, 32'd1);
      upd(32'h10, 0, 0);
      redir(32'h10);
      fetch(1);
      chk("bp_not_taken", {31'd0, bpred}, 32'd0);
      chk("bp_seq_addr", imem_addr, 32'h11);

      // Halt then redirect
      cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
      fetch(1);
      fetch(1);
      chk("halted_req", {31'd0, imem_req}, 32'd0);
      redir(32'h80);
      chk("redir_addr", imem_addr, 32'h80);
      chk("redir_bubble", {31'd0, valid}, 32'd0);
      fetch(1);
      chk("redir_instr", instr, 32'h180);

      // Redirect beats stall and ready
      cycle(1, 1, 0, 1, 32'h33, 0, 0, 0, 0);
      chk("redir_stall_instr", instr, NOP);
      chk("redir_stall_addr", imem_addr, 32'h33);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 70),
               ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 8),
               32'($urandom_range(0, 255)), ($urandom_range(0, 99) < 30),
               32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)));
      end

      // Asynchronous reset mid-stream
      fetch(1);
      fetch(1);
      #2;
      rst = 1;
      #1;
      chk_reset_outputs("async_reset");
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      fetch(1);
      fetch(1);
      chk("post_reset_instr", instr, 32'h101);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front pipeline stage: holds the program counter, fetches instructions over a ready/request instruction-memory interface, and predicts branches with a direct-mapped BHT plus BTB. Its output register feeds the instruction decode stage (instruction, next PC, prediction bit). It accepts stall and halt from decode, and redirect plus predictor updates from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first word address fetched after reset
- BHT_BITS, 6, log2 of predictor entries (64)
- NOP, 32'h0000_0000, encoding driven on oInstruction for bubbles

Ports:
- iClk  in  1  clock, all state on rising edge
- iRst  in  1  asynchronous, active-high reset
- oImemAddr  out  32  word address of current fetch
- oImemReq  out  1  fetch request
- iImemData  in  32  instruction, valid when iImemReady=1
- iImemReady  in  1  memory has data for oImemAddr this cycle
- iStall  in  1  decode cannot accept; hold output register and PC
- iHalt  in  1  halt decoded; stop fetching
- iRedirect  in  1  mispredict/jump correction from execute
- iRedirectPC  in  32  corrected fetch address
- iUpdateEn  in  1  resolved branch this cycle
- iUpdatePC  in  32  address of resolved branch
- iUpdateTaken  in  1  resolved direction
- iUpdateTarget  in  32  resolved target
- oInstruction  out  32  instruction to decode
- oNextPC  out  32  fetched PC + 1
- oBranchPredict  out  1  fetch predicted taken
- oValid  out  1  oInstruction is a real instruction

## Operation
- Word-addressed PC; sequential successor is PC+1, wraps modulo 2^32.
- States: FETCH, HALTED. Reset enters FETCH with PC=RESET_PC.
- FETCH: oImemReq = !iStall; oImemAddr = PC, held stable until accepted or redirected.
- Accept = FETCH && oImemReq && iImemReady && !iRedirect. On accept: output register loads iImemData, PC+1, prediction; oValid=1; PC <= predicted next.
- FETCH, no accept, no stall: oValid=0, oInstruction=NOP (bubble). Under iStall: output register and PC hold unchanged.
- iHalt=1 (no redirect): go to HALTED after that edge; oImemReq=0; output register takes a bubble unless iStall.
- iRedirect: highest priority, overrides stall, halt and accept. PC <= iRedirectPC; output register flushes to NOP/oValid=0/oBranchPredict=0/oNextPC=0; state <= FETCH, including from HALTED. Any outstanding request is abandoned; memory treats the new address as a new request.
- Prediction, at index i = PC[BHT_BITS-1:0]:
  - 2-bit counter per entry; BTB entry holds valid, tag = PC[31:BHT_BITS], and target.
  - Taken iff counter[1] && valid && tag match. Next PC is the BTB target if taken, else PC+1.
- Update, iUpdateEn, at index iUpdatePC[BHT_BITS-1:0]:
  - Counter saturating +1 if taken, -1 if not (range 0..3).
  - If taken, BTB entry written: valid=1, tag, and iUpdateTarget.
  - Not-taken leaves the BTB untouched.
  - Update and lookup to the same index in one cycle: lookup uses pre-update values.

## Timing
- Reset values: PC=RESET_PC, state FETCH, oInstruction=NOP, oNextPC=0, oBranchPredict=0, oValid=0. All counters=2'b01, all BTB valid=0.
- oImemAddr=RESET_PC with oImemReq=1 in the first cycle after reset deasserts.
- Fetch-to-decode latency: 1 cycle. Data accepted at edge N appears on outputs after edge N.
- Zero-wait memory (ready tied high) gives one instruction per cycle. Each wait cycle inserts one bubble.
- Redirect asserted before edge N: oImemAddr=iRedirectPC after edge N; the earliest valid output follows edge N+1.
- Predictor update takes effect for lookups after the update edge.
- Reset mid-operation immediately returns all state to reset values, asynchronously.

## Test plan
- Reset, ready tied 1, memory mem[a]=a+32'h100: oValid rises 1 cycle after first request; outputs sequence 0x100,0x101,0x102 with oNextPC 1,2,3; oBranchPredict=0.
- Ready low 2 cycles on address 5: oImemAddr stays 5, two bubbles (oValid=0, oInstruction=NOP), then mem[5] with oNextPC=6.
- iStall held 3 cycles while oValid=1: outputs and PC frozen, oImemReq=0; release resumes at the next address with no skip or duplicate.
- Two iUpdateEn taken for PC=0x10, target 0x40 (counter 01->10->11): the next fetch of 0x10 gives oBranchPredict=1 and the following oImemAddr=0x40. A not-taken update drops the counter to 10 and the prediction is still taken. A second not-taken gives 01 and the prediction is not taken.
- iHalt then iRedirect to 0x80: oImemReq=0 while HALTED; after redirect, oImemAddr=0x80 with oValid=0 for one cycle, then the instruction at 0x80.
- iRedirect together with iStall and iImemReady: redirect wins, output flushed to NOP, PC=iRedirectPC. iRst pulsed mid-stream: outputs return to reset values without waiting for a clock edge.
